shift_cmd_sequencer: RTL
========================

// Module: shift_cmd_sequencer
// PURPOSE
//   Upstream command stage for barrel_shifter. Accepts shift/rotate commands with amounts of
//   up to 2**AMT_W-1 over a valid/ready handshake and splits each into passes of at most N-1.
//   It drives barrel_shifter's A/B/opcode one pass per clock and feeds each Y back as the next A.
//   It registers the final Y and flags and presents them downstream over valid/ready.
//   Every barrel_shifter opcode composes additively: k passes of b_i equal one shift of sum(b_i).
// PARAMETERS
//   N      8   data width; power of two, >= 2; must match the barrel_shifter N
//   AMT_W  8   width of the requested total shift amount
// PORTS
//   clk           in   1           clock, all state updates on rising edge
//   rst_n         in   1           synchronous reset, active low
//   in_valid      in   1           command valid
//   in_ready      out  1           command accepted when in_valid & in_ready at clk edge
//   in_data       in   N           operand
//   in_amount     in   AMT_W       total shift amount
//   in_opcode     in   3           barrel_shifter opcode, passed through unmodified
//   bs_A          out  N           to barrel_shifter A
//   bs_B          out  $clog2(N)   to barrel_shifter B (per-pass amount)
//   bs_opcode     out  3           to barrel_shifter opcode
//   bs_Y          in   N           from barrel_shifter Y (combinational, same cycle)
//   bs_overflow   in   1           from barrel_shifter overflow_flag
//   bs_zero       in   1           from barrel_shifter zero_flag
//   out_valid     out  1           result valid
//   out_ready     in   1           downstream accepts when out_valid & out_ready at clk edge
//   out_data      out  N           final result
//   out_overflow  out  1           OR of bs_overflow over all passes of the command
//   out_zero      out  1           zero flag of final result
// BEHAVIOUR
//   Reset (rst_n low at an edge): state=IDLE; work, remaining, op, ovf_acc, out_* cleared to 0.
//     Takes effect in any state: a command mid-SHIFT or unread in DONE is discarded, nothing emitted.
//   FSM IDLE/SHIFT/DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
//   IDLE: on accept, latch work=in_data, op=in_opcode, remaining=in_amount, ovf_acc=0.
//     in_amount==0: go DONE directly, out_data=in_data, out_zero=(in_data==0), out_overflow=0.
//     in_amount!=0: go SHIFT.
//   SHIFT: bs_A=work, bs_opcode=op, step=min(remaining,N-1), bs_B=step. Each edge:
//     work<=bs_Y, remaining<=remaining-step, ovf_acc<=ovf_acc|bs_overflow.
//     If remaining==step: go DONE, out_data<=bs_Y, out_zero<=bs_zero,
//     out_overflow<=ovf_acc|bs_overflow.
//   DONE: out_* held stable while out_ready low; on out_valid&out_ready go IDLE.
//   Outside SHIFT: bs_A=work, bs_B=0, bs_opcode=op (so barrel_shifter output is don't-care).
//   Passes P=ceil(in_amount/(N-1)); accept at edge E -> out_valid high from edge E+P
//     (E itself for amount 0). One idle bubble between commands (no accept in DONE).
//   in_valid while not IDLE is ignored. in_* may change freely after acceptance.
//   Widths: remaining is AMT_W bits, never underflows (step<=remaining); step fits $clog2(N) bits.
// TESTING (N=8, AMT_W=8, real barrel_shifter connected)
//   1 rst_n=0 for 2 edges -> in_ready=1, out_valid=0, out_data=0, out_overflow=0, bs_B=0.
//   2 in_data=8'hA5, amount=0 -> out_valid high right after accept edge, out_data=8'hA5,
//     out_zero=0, out_overflow=0; bs_B stays 0.
//   3 in_data=8'b0110_1000, amount=1, opcode=3'b100 -> one SHIFT cycle with bs_B=1, out_valid at E+1,
//     out_data/out_zero = barrel_shifter(8'b0110_1000,1,3'b100) Y/zero_flag.
//   4 amount=17, opcode=3'b100 -> bs_B=7,7,3 on consecutive cycles, out_valid at E+3,
//     out_data = three chained barrel_shifter evaluations, out_overflow = OR of the three flags.
//   5 out_ready=0 for 5 cycles in DONE -> out_* stable, in_ready=0, new in_valid ignored;
//     out_ready=1 -> IDLE next edge, in_ready=1, next command accepted the edge after.
//   6 amount=20, rst_n=0 on 2nd SHIFT edge -> state IDLE next edge, out_valid never rises,
//     in_ready=1, following command processed normally.

Source files
------------

// File: rtl/shift_cmd_sequencer.sv
// Command front-end for barrel_shifter: splits a large shift amount into passes of at most N-1,
// chaining each pass result back as the next operand, and returns the final result over valid/ready.
module shift_cmd_sequencer #(
  parameter int N     = 8,
  parameter int AMT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [AMT_W-1:0]     in_amount,
  input  logic [2:0]           in_opcode,
  output logic [N-1:0]         bs_A,
  output logic [$clog2(N)-1:0] bs_B,
  output logic [2:0]           bs_opcode,
  input  logic [N-1:0]         bs_Y,
  input  logic                 bs_overflow,
  input  logic                 bs_zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_overflow,
  output logic                 out_zero
);
  localparam int BW = $clog2(N);
  localparam logic [AMT_W-1:0] MAX_STEP = AMT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [N-1:0]     work;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] step;
  logic [2:0]       op;
  logic             ovf_acc;

  assign step      = (remaining < MAX_STEP) ? remaining : MAX_STEP;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Per-pass amount is only presented while shifting so the shifter idles at B=0.
  always_comb begin
    bs_A      = work;
    bs_opcode = op;
    bs_B      = '0;
    if (state == SHIFT) bs_B = BW'(step);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      work         <= '0;
      remaining    <= '0;
      op           <= '0;
      ovf_acc      <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work      <= in_data;
            op        <= in_opcode;
            remaining <= in_amount;
            ovf_acc   <= 1'b0;
            if (in_amount == '0) begin
              state        <= DONE;
              out_data     <= in_data;
              out_zero     <= (in_data == '0);
              out_overflow <= 1'b0;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work      <= bs_Y;
          remaining <= remaining - step;
          ovf_acc   <= ovf_acc | bs_overflow;
          if (remaining == step) begin
            state        <= DONE;
            out_data     <= bs_Y;
            out_zero     <= bs_zero;
            out_overflow <= ovf_acc | bs_overflow;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
